// File: rtl/fsm_multi_ch.sv
// Multi-channel Idle/Start/Stop/Clear handshake FSM with per-channel glitch filter,
// stall timeout with lock-out, registered K1/K2/Err pulses and a shared saturating done counter.
module fsm_multi_ch #(
  parameter int unsigned CH      = 4,
  parameter int unsigned FILT    = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cnt_clr,
  input  logic [CH-1:0]     a,
  output logic [CH-1:0]     k1,
  output logic [CH-1:0]     k2,
  output logic [CH-1:0]     err,
  output logic [2*CH-1:0]   state,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int unsigned FC_W  = $clog2(FILT + 1);
  localparam int unsigned TC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMAX  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned SUM_W = CNT_W + $clog2(CH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    STOP  = 2'b10,
    CLEAR = 2'b11
  } st_e;

  st_e              st_q  [CH];
  st_e              st_n  [CH];
  logic [TC_W-1:0]  tc_q  [CH];
  logic [TC_W-1:0]  tc_n  [CH];
  logic [FC_W-1:0]  fc_q  [CH];
  logic [CH-1:0]    af_q;
  logic [CH-1:0]    lock_q;
  logic [CH-1:0]    lock_n;
  logic [CH-1:0]    k1_n;
  logic [CH-1:0]    k2_n;
  logic [CH-1:0]    err_n;
  logic [CNT_W-1:0] done_n;
  logic [SUM_W-1:0] sum;

  // Glitch filter: accept a new input level only after FILT consecutive mismatching samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= '0;
      for (int i = 0; i < CH; i++) fc_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (a[i] == af_q[i]) begin
          fc_q[i] <= '0;
        end else if (fc_q[i] == FC_W'(FILT - 1)) begin
          af_q[i] <= a[i];
          fc_q[i] <= '0;
        end else begin
          fc_q[i] <= fc_q[i] + FC_W'(1);
        end
      end
    end
  end

  // State, timeout, lock and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        st_q[i] <= IDLE;
        tc_q[i] <= '0;
      end
      lock_q   <= '0;
      k1       <= '0;
      k2       <= '0;
      err      <= '0;
      done_cnt <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        st_q[i] <= st_n[i];
        tc_q[i] <= tc_n[i];
      end
      lock_q   <= lock_n;
      k1       <= k1_n;
      k2       <= k2_n;
      err      <= err_n;
      done_cnt <= done_n;
    end
  end

  // Next-state, timeout and pulse logic; a due transition always beats the timeout
  always_comb begin
    lock_n = lock_q;
    k1_n   = '0;
    k2_n   = '0;
    err_n  = '0;
    for (int i = 0; i < CH; i++) begin
      st_n[i] = st_q[i];
      tc_n[i] = tc_q[i];
      if (en) begin
        if (st_q[i] == IDLE && !af_q[i]) lock_n[i] = 1'b0;
        unique case (st_q[i])
          IDLE:  if (af_q[i] && !lock_q[i]) st_n[i] = START;
          START: if (!af_q[i]) st_n[i] = STOP;
          STOP:  if (af_q[i]) begin
                   st_n[i] = CLEAR;
                   k2_n[i] = 1'b1;
                 end
          CLEAR: if (!af_q[i]) begin
                   st_n[i] = IDLE;
                   k1_n[i] = 1'b1;
                 end
        endcase
        if (st_n[i] != st_q[i]) begin
          tc_n[i] = '0;
        end else if (TIMEOUT > 0 && (st_q[i] == START || st_q[i] == STOP)) begin
          if (tc_q[i] == TC_W'(TMAX)) begin
            st_n[i]   = IDLE;
            lock_n[i] = 1'b1;
            err_n[i]  = 1'b1;
            tc_n[i]   = '0;
          end else begin
            tc_n[i] = tc_q[i] + TC_W'(1);
          end
        end
      end
    end
  end

  // Saturating completed-cycle counter; clear wins over increment
  always_comb begin
    sum = SUM_W'(done_cnt);
    for (int i = 0; i < CH; i++) sum = sum + SUM_W'(k1_n[i]);
    if (cnt_clr) begin
      done_n = '0;
    end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
      done_n = '1;
    end else begin
      done_n = CNT_W'(sum);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_state
    assign state[2*g+1:2*g] = st_q[g];
  end

endmodule

// File: tb/tb_fsm_multi_ch.sv
// Randomized bench for fsm_multi_ch checked each cycle against a behavioural model
// of filtered inputs, phase progression, stall timeout and the saturating done count.
module tb_fsm_multi_ch;

  localparam int unsigned CH      = 4;
  localparam int unsigned FILT    = 3;
  localparam int unsigned TIMEOUT = 12;
  localparam int unsigned CNT_W   = 3;
  localparam int          DMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              cnt_clr;
  logic [CH-1:0]     a;
  logic [CH-1:0]     k1;
  logic [CH-1:0]     k2;
  logic [CH-1:0]     err;
  logic [2*CH-1:0]   state;
  logic [CNT_W-1:0]  done_cnt;

  always #5 clk = ~clk;

  fsm_multi_ch #(.CH(CH), .FILT(FILT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt_clr(cnt_clr), .a(a),
    .k1(k1), .k2(k2), .err(err), .state(state), .done_cnt(done_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Model: phase 0..3 advances when the filtered level equals the level that phase waits for
  int m_phase [CH];
  int m_af    [CH];
  int m_run   [CH];
  int m_stall [CH];
  int m_lock  [CH];
  int m_k1    [CH];
  int m_k2    [CH];
  int m_err   [CH];
  int m_done;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_phase[i] = 0; m_af[i] = 0; m_run[i] = 0; m_stall[i] = 0;
      m_lock[i] = 0; m_k1[i] = 0; m_k2[i] = 0; m_err[i] = 0;
    end
    m_done = 0;
  endtask

  task automatic model_step();
    int completed = 0;
    for (int i = 0; i < CH; i++) begin
      int want;
      bit due;
      m_k1[i] = 0; m_k2[i] = 0; m_err[i] = 0;
      if (en) begin
        want = (m_phase[i] % 2 == 0) ? 1 : 0;
        due  = (m_af[i] == want) && !(m_phase[i] == 0 && m_lock[i] != 0);
        if (m_phase[i] == 0 && m_af[i] == 0) m_lock[i] = 0;
        if (due) begin
          if (m_phase[i] == 2) m_k2[i] = 1;
          if (m_phase[i] == 3) m_k1[i] = 1;
          m_phase[i] = (m_phase[i] + 1) % 4;
          m_stall[i] = 0;
        end else if (TIMEOUT > 0 && (m_phase[i] == 1 || m_phase[i] == 2)) begin
          m_stall[i]++;
          if (m_stall[i] == TIMEOUT) begin
            m_phase[i] = 0; m_lock[i] = 1; m_err[i] = 1; m_stall[i] = 0;
          end
        end
      end
      completed += m_k1[i];
      if (int'(a[i]) == m_af[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == FILT) begin
          m_af[i] = int'(a[i]);
          m_run[i] = 0;
        end
      end
    end
    if (cnt_clr) m_done = 0;
    else m_done = (m_done + completed > DMAX) ? DMAX : m_done + completed;
  endtask

  task automatic compare_all();
    int unsigned es = 0, e1 = 0, e2 = 0, ee = 0;
    for (int i = 0; i < CH; i++) begin
      es += m_phase[i] << (2 * i);
      e1 += m_k1[i] << i;
      e2 += m_k2[i] << i;
      ee += m_err[i] << i;
    end
    check("state", state, es);
    check("k1", k1, e1);
    check("k2", k2, e2);
    check("err", err, ee);
    check("done_cnt", done_cnt, m_done);
  endtask

  int hold [CH];

  function automatic int pick_hold();
    int r = $urandom_range(0, 99);
    if (r < 15) return $urandom_range(1, FILT - 1);
    if (r < 27) return $urandom_range(TIMEOUT + 2, TIMEOUT + 8);
    return $urandom_range(FILT, FILT + 6);
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; cnt_clr = 1'b0; a = '0;
    model_reset();
    for (int i = 0; i < CH; i++) hold[i] = pick_hold();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (cyc == 2000 || cyc == 3200) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      en      = (cyc >= 500 && cyc < 510) ? 1'b0 : ($urandom_range(0, 99) < 90);
      cnt_clr = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < CH; i++) begin
        if (hold[i] == 0) begin
          a[i] = ~a[i];
          hold[i] = pick_hold();
        end else begin
          hold[i]--;
        end
      end
      // Lockstep window: all channels follow channel 0 to produce simultaneous K1 pulses
      if (cyc >= 1000 && cyc < 1600) a = {CH{a[0]}};
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
